// File: rtl/ip_pack.sv
// ip_pack: builds the 20-byte IPv4 header with checksum into the TX buffer RAM
module ip_pack #(
  parameter logic [9:0]  IP_BASE_ADDR = 10'd22,
  parameter logic [7:0]  IP_TOS       = 8'h00,
  parameter logic [7:0]  IP_TTL       = 8'h40,
  parameter logic [7:0]  IP_PROT      = 8'h11,
  parameter logic [15:0] IDENT_INIT   = 16'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ip_head_start,
  input  logic [31:0] src_ip_addr,
  input  logic [31:0] des_ip_addr,
  input  logic [15:0] ip_total_len,
  output logic        ip_wram_clk_en,
  output logic [9:0]  ip_wram_addr,
  output logic [7:0]  ip_wram_dat,
  output logic        ip_head_end,
  output logic        ip_busy
);
  typedef enum logic [2:0] {S_IDLE, S_CALC, S_FOLD, S_WRITE, S_DONE} state_t;
  state_t      r_state, w_next;
  logic [4:0]  r_cnt;
  logic [19:0] r_sum;
  logic [31:0] r_src, r_des;
  logic [15:0] r_len, r_ident, w_word;
  logic [3:0]  w_idx;
  logic [7:0]  w_byte;
  assign w_idx  = (r_state == S_WRITE) ? r_cnt[4:1] : r_cnt[3:0];
  assign w_byte = r_cnt[0] ? w_word[7:0] : w_word[15:8];
  // header word selected by index; checksum slot is zero while summing
  always_comb begin
    w_word = 16'h0;
    case (w_idx)
      4'd0: w_word = {4'h4, 4'h5, IP_TOS};
      4'd1: w_word = r_len;
      4'd2: w_word = r_ident;
      4'd3: w_word = 16'h4000;
      4'd4: w_word = {IP_TTL, IP_PROT};
      4'd5: w_word = (r_state == S_WRITE) ? ~r_sum[15:0] : 16'h0;
      4'd6: w_word = r_src[31:16];
      4'd7: w_word = r_src[15:0];
      4'd8: w_word = r_des[31:16];
      4'd9: w_word = r_des[15:0];
      default: w_word = 16'h0;
    endcase
  end
  // next-state sequencing through the fixed-length phases
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  w_next = ip_head_start ? S_CALC : S_IDLE;
      S_CALC:  w_next = (r_cnt == 5'd9) ? S_FOLD : S_CALC;
      S_FOLD:  w_next = (r_cnt == 5'd1) ? S_WRITE : S_FOLD;
      S_WRITE: w_next = (r_cnt == 5'd19) ? S_DONE : S_WRITE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end
  // state register and phase counter, restarting the count on every phase change
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= 5'd0;
    end else begin
      r_state <= w_next;
      r_cnt   <= (w_next != r_state) ? 5'd0 : r_cnt + 5'd1;
    end
  end
  // field latch, checksum accumulation/folding and ident advance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_src   <= 32'h0;
      r_des   <= 32'h0;
      r_len   <= 16'h0;
      r_sum   <= 20'h0;
      r_ident <= IDENT_INIT;
    end else begin
      if (r_state == S_IDLE && ip_head_start) begin
        r_src <= src_ip_addr;
        r_des <= des_ip_addr;
        r_len <= ip_total_len;
        r_sum <= 20'h0;
      end
      if (r_state == S_CALC) r_sum <= r_sum + {4'h0, w_word};
      if (r_state == S_FOLD)
        r_sum <= (r_cnt == 5'd0) ? {4'h0, r_sum[15:0]} + {16'h0, r_sum[19:16]}
                                 : {4'h0, r_sum[15:0]} + {19'h0, r_sum[16]};
      if (r_state == S_DONE) r_ident <= r_ident + 16'h1;
    end
  end
  // registered RAM write port, completion pulse and busy flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ip_wram_clk_en <= 1'b0;
      ip_wram_addr   <= 10'h0;
      ip_wram_dat    <= 8'h0;
      ip_head_end    <= 1'b0;
      ip_busy        <= 1'b0;
    end else begin
      ip_wram_clk_en <= (r_state == S_WRITE);
      ip_wram_dat    <= (r_state == S_WRITE) ? w_byte : 8'h0;
      ip_wram_addr   <= (r_state == S_WRITE) ? IP_BASE_ADDR + {5'h0, r_cnt} : ip_wram_addr;
      ip_head_end    <= (r_state == S_DONE);
      ip_busy        <= (w_next != S_IDLE) || (r_state == S_DONE);
    end
  end
endmodule
